// File: rtl/stash_scan_controller_pkg.sv
// Shared definitions for the stash scan controller and its table walker:
// default widths, path-length derivation, the null stash address and the
// state encodings of both FSMs.
package stash_scan_controller_pkg;

  localparam int unsigned ORAML_DEF             = 32;
  localparam int unsigned ORAMZ_DEF             = 4;
  localparam int unsigned STASH_EA_WIDTH_DEF    = 8;
  localparam int unsigned SCAN_TABLE_AWIDTH_DEF = 8;

  // Number of block slots on one root-to-leaf path.
  function automatic int unsigned blocks_on_path(input int unsigned oram_l,
                                                 input int unsigned oram_z);
    return (oram_l + 1) * oram_z;
  endfunction

  localparam int unsigned BLOCKS_ON_PATH_DEF = blocks_on_path(ORAML_DEF, ORAMZ_DEF);

  // Empty scan table entry marker (all ones of the stash address width).
  localparam logic [STASH_EA_WIDTH_DEF-1:0] SNULL = '1;

  // Controller phases; WALK covers the whole table walk owned by the walker.
  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    CLEAR = 3'd2,
    SCAN  = 3'd3,
    DRAIN = 3'd4,
    WALK  = 3'd5
  } ctrl_state_e;

  // Table walker steps.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    RD     = 2'd1,
    CLR    = 2'd2,
    OUT    = 2'd3
  } walk_state_e;

endpackage

// File: rtl/stash_scan_walker.sv
// Walks the scan table in ascending address order: reads each entry, clears
// it, and hands every non-null stash address to the writeback engine.
module stash_scan_walker
  import stash_scan_controller_pkg::*;
#(
  parameter int unsigned StashEAWidth    = STASH_EA_WIDTH_DEF,
  parameter int unsigned ScanTableAWidth = SCAN_TABLE_AWIDTH_DEF,
  parameter int unsigned BlocksOnPath    = BLOCKS_ON_PATH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       done,
  output logic [ScanTableAWidth-1:0] st_addr,
  output logic                       st_valid,
  output logic                       st_reset,
  input  logic [StashEAWidth-1:0]    st_data,
  input  logic                       st_data_valid,
  output logic [StashEAWidth-1:0]    wb_addr,
  output logic                       wb_valid,
  input  logic                       wb_ready
);

  localparam logic [ScanTableAWidth-1:0] LAST_Q = ScanTableAWidth'(BlocksOnPath - 1);
  localparam logic [StashEAWidth-1:0]    NULL_ADDR = '1;

  walk_state_e                state, state_nxt;
  logic [ScanTableAWidth-1:0] q, q_nxt;
  logic [StashEAWidth-1:0]    cap, cap_nxt;
  logic                       advance;

  // Walker state, table pointer and captured entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= W_IDLE;
      q     <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cap   <= cap_nxt;
    end
  end

  // Step sequencing. The pointer advance is taken directly from CLR (null
  // entry) or OUT (handshake) so a null entry costs two cycles, not three.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cap_nxt   = cap;
    advance   = 1'b0;
    done      = 1'b0;
    st_addr   = '0;
    st_valid  = 1'b0;
    st_reset  = 1'b0;
    wb_addr   = '0;
    wb_valid  = 1'b0;
    case (state)
      W_IDLE: begin
        if (start) begin
          q_nxt     = '0;
          state_nxt = RD;
        end
      end
      RD: begin
        st_valid  = 1'b1;
        st_addr   = q;
        state_nxt = CLR;
      end
      CLR: begin
        st_reset = 1'b1;
        st_addr  = q;
        cap_nxt  = st_data;
        if (st_data_valid && (st_data != NULL_ADDR)) state_nxt = OUT;
        else                                         advance   = 1'b1;
      end
      OUT: begin
        wb_valid = 1'b1;
        wb_addr  = cap;
        if (wb_ready) advance = 1'b1;
      end
      default: state_nxt = W_IDLE;
    endcase
    if (advance) begin
      if (q == LAST_Q) begin
        done      = 1'b1;
        state_nxt = W_IDLE;
      end else begin
        q_nxt     = q + ScanTableAWidth'(1);
        state_nxt = RD;
      end
    end
  end

endmodule

// File: rtl/stash_scan_controller.sv
// Per-access stash scan sequencer: clears the scan table's per-access state,
// streams every occupied stash entry into the table, then lets the walker
// drain the table to the writeback engine.
// Optional statistics counters are enabled by defining STASH_SCAN_STATS_EN.
module stash_scan_controller
  import stash_scan_controller_pkg::*;
#(
  parameter int unsigned ORAML           = ORAML_DEF,
  parameter int unsigned ORAMZ           = ORAMZ_DEF,
  parameter int unsigned StashEAWidth    = STASH_EA_WIDTH_DEF,
  parameter int unsigned ScanTableAWidth = SCAN_TABLE_AWIDTH_DEF,
  parameter int unsigned BlocksOnPath    = blocks_on_path(ORAML, ORAMZ)
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [ORAML-1:0]           AccessLeaf,
  output logic                       StartReady,
  output logic                       Done,
  output logic [StashEAWidth-1:0]    StashRdAddr,
  output logic                       StashRdEn,
  input  logic [ORAML-1:0]           StashRdLeaf,
  input  logic                       StashRdOccupied,
  output logic                       STPerAccessReset,
  input  logic                       STResetDone,
  output logic [ORAML-1:0]           STCurrentLeaf,
  output logic [ORAML-1:0]           STInLeaf,
  output logic [StashEAWidth-1:0]    STInSAddr,
  output logic                       STInValid,
  input  logic                       STOutAccepted,
  output logic [ScanTableAWidth-1:0] STInSTAddr,
  output logic                       STInSTValid,
  output logic                       STInSTReset,
  input  logic [StashEAWidth-1:0]    STOutSTAddr,
  input  logic                       STOutSTValid,
  output logic [StashEAWidth-1:0]    WBSAddr,
  output logic                       WBValid,
  input  logic                       WBReady,
  output logic [ScanTableAWidth:0]   AcceptCount,
  output logic [StashEAWidth:0]      RejectCount
);

  localparam logic [StashEAWidth-1:0] LAST_P = '1;

  ctrl_state_e               state, state_nxt;
  logic [StashEAWidth-1:0]   p;
  logic [StashEAWidth-1:0]   rd_addr_d;
  logic                      rd_pend;
  logic [ORAML-1:0]          cur_leaf;
  logic                      walk_start;
  logic                      walk_done;

  // Controller state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= INIT;
    else        state <= state_nxt;
  end

  // Phase sequencing and per-phase strobes.
  always_comb begin
    state_nxt        = state;
    StartReady       = 1'b0;
    STPerAccessReset = 1'b0;
    StashRdEn        = 1'b0;
    StashRdAddr      = '0;
    walk_start       = 1'b0;
    case (state)
      INIT:  if (STResetDone) state_nxt = IDLE;
      IDLE: begin
        StartReady = 1'b1;
        if (Start) state_nxt = CLEAR;
      end
      CLEAR: begin
        STPerAccessReset = 1'b1;
        state_nxt        = SCAN;
      end
      SCAN: begin
        StashRdEn   = 1'b1;
        StashRdAddr = p;
        if (p == LAST_P) state_nxt = DRAIN;
      end
      DRAIN: begin
        walk_start = 1'b1;
        state_nxt  = WALK;
      end
      WALK:    if (walk_done) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Stash pointer, read-response alignment and the access leaf.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      p         <= '0;
      rd_addr_d <= '0;
      rd_pend   <= 1'b0;
      cur_leaf  <= '0;
    end else begin
      if (state == CLEAR)     p <= '0;
      else if (state == SCAN) p <= p + StashEAWidth'(1);
      rd_addr_d <= p;
      rd_pend   <= (state == SCAN);
      if ((state == IDLE) && Start) cur_leaf <= AccessLeaf;
    end
  end

  assign STInValid     = rd_pend & StashRdOccupied;
  assign STInSAddr     = STInValid ? rd_addr_d : '0;
  assign STInLeaf      = STInValid ? StashRdLeaf : '0;
  assign STCurrentLeaf = cur_leaf;
  assign Done          = walk_done;

  stash_scan_walker #(
    .StashEAWidth   (StashEAWidth),
    .ScanTableAWidth(ScanTableAWidth),
    .BlocksOnPath   (BlocksOnPath)
  ) u_walker (
    .clk          (Clock),
    .rst_n        (Reset),
    .start        (walk_start),
    .done         (walk_done),
    .st_addr      (STInSTAddr),
    .st_valid     (STInSTValid),
    .st_reset     (STInSTReset),
    .st_data      (STOutSTAddr),
    .st_data_valid(STOutSTValid),
    .wb_addr      (WBSAddr),
    .wb_valid     (WBValid),
    .wb_ready     (WBReady)
  );

`ifdef STASH_SCAN_STATS_EN
  localparam int unsigned ACW = ScanTableAWidth + 1;
  localparam int unsigned RCW = StashEAWidth + 1;

  // Accept/reject tallies, cleared at the start of each access.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      AcceptCount <= '0;
      RejectCount <= '0;
    end else if (state == CLEAR) begin
      AcceptCount <= '0;
      RejectCount <= '0;
    end else if (STInValid) begin
      if (STOutAccepted) AcceptCount <= AcceptCount + ACW'(1);
      else               RejectCount <= RejectCount + RCW'(1);
    end
  end

`ifndef SYNTHESIS
  logic [ACW-1:0] wb_handshakes;

  // Writeback handshakes this access, compared with accepts at completion.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                 wb_handshakes <= '0;
    else if (state == CLEAR)    wb_handshakes <= '0;
    else if (WBValid && WBReady) wb_handshakes <= wb_handshakes + ACW'(1);
  end

  // Every accepted block must leave through writeback by the end of the walk.
  always_ff @(posedge Clock) begin
    if (Reset && Done)
      assert (AcceptCount == wb_handshakes + ACW'(WBValid & WBReady));
  end
`endif
`else
  logic stats_unused;
  assign stats_unused = STOutAccepted;
  assign AcceptCount  = '0;
  assign RejectCount  = '0;
`endif

endmodule

// File: tb/tb_stash_scan_controller.sv
// Scoreboard bench for stash_scan_controller: behavioural stash memory and
// scan table models, expected-response queues filled by the stimulus and
// drained by a monitor. Statistics expectations follow STASH_SCAN_STATS_EN.
module tb_stash_scan_controller;
  import stash_scan_controller_pkg::*;

  logic        Clock, Reset, Start;
  logic [31:0] AccessLeaf;
  logic        StartReady, Done;
  logic [7:0]  StashRdAddr;
  logic        StashRdEn;
  logic [31:0] StashRdLeaf;
  logic        StashRdOccupied;
  logic        STPerAccessReset, STResetDone;
  logic [31:0] STCurrentLeaf, STInLeaf;
  logic [7:0]  STInSAddr;
  logic        STInValid, STOutAccepted;
  logic [7:0]  STInSTAddr;
  logic        STInSTValid, STInSTReset;
  logic [7:0]  STOutSTAddr;
  logic        STOutSTValid;
  logic [7:0]  WBSAddr;
  logic        WBValid, WBReady;
  logic [8:0]  AcceptCount, RejectCount;

  stash_scan_controller dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .AccessLeaf(AccessLeaf),
    .StartReady(StartReady), .Done(Done),
    .StashRdAddr(StashRdAddr), .StashRdEn(StashRdEn),
    .StashRdLeaf(StashRdLeaf), .StashRdOccupied(StashRdOccupied),
    .STPerAccessReset(STPerAccessReset), .STResetDone(STResetDone),
    .STCurrentLeaf(STCurrentLeaf), .STInLeaf(STInLeaf), .STInSAddr(STInSAddr),
    .STInValid(STInValid), .STOutAccepted(STOutAccepted),
    .STInSTAddr(STInSTAddr), .STInSTValid(STInSTValid), .STInSTReset(STInSTReset),
    .STOutSTAddr(STOutSTAddr), .STOutSTValid(STOutSTValid),
    .WBSAddr(WBSAddr), .WBValid(WBValid), .WBReady(WBReady),
    .AcceptCount(AcceptCount), .RejectCount(RejectCount)
  );

  logic [121:0] all_outs;
  assign all_outs = {StartReady, Done, StashRdAddr, StashRdEn, STPerAccessReset,
                     STCurrentLeaf, STInLeaf, STInSAddr, STInValid, STInSTAddr,
                     STInSTValid, STInSTReset, WBSAddr, WBValid, AcceptCount, RejectCount};

  // Behavioural stash memory and scan table contents (written only by stimulus)
  logic        occ_mem [256];
  logic [31:0] leaf_mem[256];
  logic        acc_map [256];
  logic [7:0]  tbl     [132];

  logic [39:0] exp_in[$];
  logic [7:0]  exp_wb[$];

  int checks = 0, errors = 0;
  int per_reset_cnt, in_cnt, rd_cnt, rd_exp, rst_exp, wb_cnt, done_cnt;
  logic [39:0] e_in;
  logic [7:0]  e_wb;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Registered read ports of the stash memory and the scan table
  always @(posedge Clock) begin
    StashRdOccupied <= StashRdEn ? occ_mem[StashRdAddr] : 1'b0;
    StashRdLeaf     <= StashRdEn ? leaf_mem[StashRdAddr] : 32'h0;
    STOutSTValid    <= STInSTValid;
    STOutSTAddr     <= (STInSTValid && STInSTAddr < 8'd132) ? tbl[STInSTAddr] : 8'h0;
  end

  always_comb STOutAccepted = acc_map[STInSAddr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event, expected one within the cycle budget", name);
  endtask

  // Monitor: pops expected responses whenever the DUT presents them
  always @(negedge Clock) begin
    if (Reset) begin
      if (STPerAccessReset) begin
        per_reset_cnt++;
        check("per_reset_before_in", in_cnt, 0);
        rd_exp  = 0;
        rst_exp = 0;
      end
      if (StashRdEn) begin
        check("rd_addr", StashRdAddr, rd_exp);
        rd_exp++;
        rd_cnt++;
      end
      if (STInValid) begin
        check("in_exclusive", {STInSTValid, STInSTReset, STPerAccessReset}, 0);
        if (exp_in.size() == 0) fail("in_expected_entry");
        else begin
          e_in = exp_in.pop_front();
          check("in_saddr", STInSAddr, e_in[39:32]);
          check("in_leaf", STInLeaf, e_in[31:0]);
        end
        in_cnt++;
      end
      if (STInSTReset) begin
        check("st_reset_addr", STInSTAddr, rst_exp);
        rst_exp++;
      end
      if (WBValid && WBReady) begin
        if (exp_wb.size() == 0) fail("wb_expected_entry");
        else begin
          e_wb = exp_wb.pop_front();
          check("wb_saddr", WBSAddr, e_wb);
        end
        wb_cnt++;
      end
      if (Done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic nwait();
    @(negedge Clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      occ_mem[i]  = 1'b0;
      leaf_mem[i] = 32'h0;
      acc_map[i]  = 1'b0;
    end
    for (int i = 0; i < 132; i++) tbl[i] = SNULL;
    exp_in.delete();
    exp_wb.delete();
    per_reset_cnt = 0; in_cnt = 0; rd_cnt = 0; rd_exp = 0;
    rst_exp = 0; wb_cnt = 0; done_cnt = 0;
  endtask

  task automatic add_stash(input int a, input logic [31:0] lf, input logic ac);
    occ_mem[a]  = 1'b1;
    leaf_mem[a] = lf;
    acc_map[a]  = ac;
    exp_in.push_back({8'(a), lf});
  endtask

  task automatic add_tbl(input int q, input logic [7:0] s);
    tbl[q] = s;
    exp_wb.push_back(s);
  endtask

  task automatic start_access(input logic [31:0] lf);
    int n = 0;
    while (!StartReady && n < 20) begin nwait(); n++; end
    if (!StartReady) fail("start_ready_timeout");
    tick();
    AccessLeaf = lf;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
  endtask

  task automatic finish_access(input logic [31:0] lf, input int acc, input int rej);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin nwait(); n++; end
    if (done_cnt == 0) fail("done_timeout");
    repeat (3) nwait();
    check("done_once", done_cnt, 1);
    check("per_reset_once", per_reset_cnt, 1);
    check("stash_reads", rd_cnt, 256);
    check("table_resets", rst_exp, 132);
    check("in_queue_empty", exp_in.size(), 0);
    check("wb_queue_empty", exp_wb.size(), 0);
    check("leaf_held", STCurrentLeaf, lf);
    check("idle_after_done", StartReady, 1);
`ifdef STASH_SCAN_STATS_EN
    check("accept_count", AcceptCount, acc);
    check("reject_count", RejectCount, rej);
`else
    check("accept_count_tied", AcceptCount, 0);
    check("reject_count_tied", RejectCount, 0);
`endif
  endtask

  task automatic stall_first(input logic [7:0] s);
    int n = 0;
    while (!WBValid && n < 2000) begin nwait(); n++; end
    if (!WBValid) begin
      fail("wb_stall_timeout");
      WBReady = 1'b1;
      return;
    end
    check("wb_stall_hold", {WBValid, WBSAddr}, {1'b1, s});
    repeat (9) begin
      nwait();
      check("wb_stall_hold", {WBValid, WBSAddr}, {1'b1, s});
    end
    tick();
    WBReady = 1'b1;
    nwait();
    check("wb_stall_release", {WBValid, WBSAddr}, {1'b1, s});
  endtask

  task automatic setup_abort_case();
    clear_model();
    add_stash(10, 32'h0000_0010, 1'b1);
    add_stash(60, 32'h0000_0060, 1'b1);
    add_tbl(7, 8'd60);
    add_tbl(30, 8'd10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic found;
    Reset = 1'b1; Start = 1'b0; AccessLeaf = 32'h0; STResetDone = 1'b0; WBReady = 1'b1;
    clear_model();
    #2 Reset = 1'b0;

    // Reset and scan table initialisation handshake
    nwait();
    check("outs_zero_reset", 64'(|all_outs), 0);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nwait();
      check("not_ready_before_table", StartReady, 0);
    end
    tick();
    STResetDone = 1'b1;
    nwait();
    check("not_ready_same_cycle", StartReady, 0);
    nwait();
    check("ready_after_table", StartReady, 1);

    // Entries 3 and 7 occupied; table holds 7 at 0 and 3 at 4; stray Start ignored
    clear_model();
    add_stash(3, 32'h0000_0A03, 1'b1);
    add_stash(7, 32'h1234_5677, 1'b1);
    add_tbl(0, 8'd7);
    add_tbl(4, 8'd3);
    start_access(32'h0000_00AA);
    repeat (20) tick();
    AccessLeaf = 32'h5555_5555;
    Start      = 1'b1;
    tick();
    Start      = 1'b0;
    finish_access(32'h0000_00AA, 2, 0);

    // Boundary entries 0/255, non-null 0 and 254, last slot valid, stalled writeback
    clear_model();
    add_stash(0,   32'hFFFF_FFFF, 1'b1);
    add_stash(128, 32'h8000_0001, 1'b1);
    add_stash(255, 32'h7FFF_FFFE, 1'b1);
    add_tbl(10,  8'd0);
    add_tbl(50,  8'd254);
    add_tbl(131, 8'd128);
    WBReady = 1'b0;
    start_access(32'h0F0F_0F0F);
    stall_first(8'd0);
    finish_access(32'h0F0F_0F0F, 3, 0);

    // Reset in the middle of the stash scan, then a clean restart
    setup_abort_case();
    start_access(32'hCAFE_0005);
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(negedge Clock);
      if (StashRdEn && StashRdAddr == 8'd40) found = 1'b1;
      n++;
    end
    if (!found) fail("scan_p40_timeout");
    #1 Reset = 1'b0;
    #1 check("outs_zero_abort", 64'(|all_outs), 0);
    repeat (2) tick();
    check("no_done_after_abort", done_cnt, 0);
    check("no_wb_after_abort", wb_cnt, 0);
    Reset = 1'b1;
    setup_abort_case();
    start_access(32'hCAFE_0006);
    finish_access(32'hCAFE_0006, 2, 0);

    // Five occupied entries, three accepted
    clear_model();
    add_stash(1,   32'h0000_0101, 1'b1);
    add_stash(2,   32'h0000_0102, 1'b0);
    add_stash(5,   32'h0000_0105, 1'b1);
    add_stash(9,   32'h0000_0109, 1'b0);
    add_stash(200, 32'h0000_01C8, 1'b1);
    add_tbl(2,   8'd1);
    add_tbl(20,  8'd5);
    add_tbl(100, 8'd200);
    start_access(32'h0000_0006);
    finish_access(32'h0000_0006, 3, 2);

    // Counters restart from zero on the next access
    clear_model();
    add_stash(4, 32'h0000_4444, 1'b1);
    add_tbl(3, 8'd4);
    start_access(32'h0000_0007);
    n = 0;
    found = 1'b0;
    while (!found && n < 10) begin
      @(negedge Clock);
      if (STPerAccessReset) found = 1'b1;
      n++;
    end
    if (!found) fail("clear_timeout");
    nwait();
    check("stats_cleared", {AcceptCount, RejectCount}, 0);
    finish_access(32'h0000_0007, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stash_scan_controller.md
Name: stash_scan_controller

Overview:
Per-access sequencer for the stash scan table. On each ORAM access it:
- clears the table's per-access bucket counters;
- streams every occupied stash entry (address plus leaf) through the table's accept/reject port;
- walks the table in address order and hands each non-null stash address to the writeback engine;
- resets each walked table entry to SNULL so the table is ready for the next access.

It sits between the stash top level (stash entry memory, writeback path) and the scan table.

Parameters:
- ORAML, 32, leaf label width.
- ORAMZ, 4, blocks per bucket.
- StashEAWidth, 8, stash entry address width; stash capacity is 2^StashEAWidth entries.
- ScanTableAWidth, 8, scan table address width.
- BlocksOnPath, 132, (ORAML+1)*ORAMZ; number of scan table entries walked.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin access; sampled only while StartReady=1.
- AccessLeaf  in  ORAML  leaf of the current access; registered on Start.
- StartReady  out  1  idle and able to accept Start.
- Done  out  1  one-cycle pulse when the access completes.
- StashRdAddr  out  StashEAWidth  stash entry to read.
- StashRdEn  out  1  stash read strobe.
- StashRdLeaf  in  ORAML  leaf of the read entry; valid 1 cycle after StashRdEn.
- StashRdOccupied  in  1  entry holds a real block; valid 1 cycle after StashRdEn.
- STPerAccessReset  out  1  to scan table PerAccessReset.
- STResetDone  in  1  from scan table ResetDone.
- STCurrentLeaf  out  ORAML  registered AccessLeaf.
- STInLeaf  out  ORAML  to scan table InLeaf.
- STInSAddr  out  StashEAWidth  to scan table InSAddr.
- STInValid  out  1  to scan table InValid.
- STOutAccepted  in  1  from scan table OutAccepted.
- STInSTAddr  out  ScanTableAWidth  scan address.
- STInSTValid  out  1  scan read strobe.
- STInSTReset  out  1  scan entry clear strobe.
- STOutSTAddr  in  StashEAWidth  scan read data.
- STOutSTValid  in  1  scan read data valid, 1 cycle after STInSTValid.
- WBSAddr  out  StashEAWidth  stash entry to write back.
- WBValid  out  1  WBSAddr valid.
- WBReady  in  1  writeback engine accepts WBSAddr.
- AcceptCount  out  ScanTableAWidth+1  blocks accepted this access (statistics).
- RejectCount  out  StashEAWidth+1  blocks rejected this access (statistics).

Behaviour:
- Reset (Reset=0, asynchronous):
  - state = INIT; all outputs 0; counters 0.
  - Reset may assert in any state; the access is abandoned, with no Done and no WBValid.
- INIT: wait for STResetDone=1, then go to IDLE.
- IDLE:
  - StartReady=1.
  - On Start: register AccessLeaf, go to CLEAR.
  - Start while StartReady=0 is ignored.
- CLEAR: STPerAccessReset=1 for exactly 1 cycle; stash pointer p=0; then SCAN.
- SCAN:
  - Each cycle: StashRdEn=1, StashRdAddr=p, p increments.
  - One cycle later, if StashRdOccupied=1: STInValid=1, STInSAddr = delayed p, STInLeaf = StashRdLeaf.
  - Unoccupied entries never raise STInValid.
  - On the cycle p=2^StashEAWidth-1 is issued, go to DRAIN (no wrap-around).
- DRAIN: 1 cycle, for the last read's response; scan pointer q=0; then RD.
- RD: STInSTValid=1, STInSTAddr=q; go to CLR.
- CLR:
  - STInSTReset=1, STInSTAddr=q.
  - Capture STOutSTAddr (STOutSTValid=1 this cycle).
  - If the captured value != SNULL, go to OUT; otherwise go to NEXT.
- OUT: WBValid=1, WBSAddr = captured value, held stable until WBReady=1; then NEXT. WBValid with no WBReady holds indefinitely.
- NEXT:
  - If q=BlocksOnPath-1, pulse Done and go to IDLE.
  - Otherwise q increments and the state returns to RD.
- Table walk is stricly in ascending address order. Per-entry latency: 2 cycles for SNULL entries, at least 3 for valid entries.
- Invariants:
  - STInValid and STInSTValid/STInSTReset are never asserted in the same cycle.
  - STPerAccessReset is never asserted with STInValid.
- STCurrentLeaf is held constant from CLEAR to Done.

Optional Feature:
- STASH_SCAN_STATS_EN defined:
  - AcceptCount increments on each STInValid & STOutAccepted.
  - RejectCount increments on each STInValid & ~STOutAccepted.
  - Both clear in CLEAR and are held after Done.
  - Simulation-only assertion: at Done, AcceptCount equals the number of WBValid handshakes.
- STASH_SCAN_STATS_EN undefined: AcceptCount and RejectCount are tied to 0; no counter logic.

Decomposition:
- Shared package: SNULL = all-ones of StashEAWidth; state encoding (INIT, IDLE, CLEAR, SCAN, DRAIN, RD, CLR, OUT, NEXT); BlocksOnPath derivation.
- Natural sub-module: stash_scan_walker. It owns q, RD/CLR/OUT/NEXT and the writeback handshake, and is started by the parent after DRAIN.

Test Plan:
1. Reset released with STResetDone rising 5 cycles later: StartReady=0 until the cycle after STResetDone=1, then StartReady=1; all outputs 0 during reset.
2. Stash entries 3 and 7 occupied, all other entries empty:
   - Start -> exactly 2 STInValid pulses, with SAddr 3 then 7 and leaves as supplied.
   - STPerAccessReset occurs exactly once, before them.
3. Table holds 7 at address 0, 3 at address 4, SNULL elsewhere; WBReady=1:
   - WBSAddr sequence is 7 then 3.
   - 132 STInSTReset pulses, one for each address 0..131.
   - Done once.
4. WBReady held low 10 cycles on the first valid entry: WBValid and WBSAddr stable for 11 cycles; walk resumes after the handshake.
5. Reset asserted mid-SCAN at p=40: outputs 0 immediately; no Done; next Start restarts from CLEAR with p=0.
6. STASH_SCAN_STATS_EN, 5 occupied entries, 3 accepted: AcceptCount=3, RejectCount=2 at Done; both zero after the next CLEAR.
